vload_sequencer: RTL and testbench
==================================

Name: vload_sequencer

Overview:
- Load-stage sequencer that sits directly upstream of the data-memory ROM and drives its isVector/address inputs.
- It captures the ROM's 192-bit read data and returns it to the writeback stage over a valid/ready handshake.
- Contiguous vector loads (stride 1) and scalar loads take one ROM access each.
- Strided vector loads are gathered as 6 sequential scalar ROM accesses, one lane per cycle.

Parameters:
- S, 32, scalar word / address width
- V, 192, vector width (LANES*S)
- SIZE, 30000, ROM depth in words; used only by the optional bounds check
- TAGW, 5, destination register tag width

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  load request present
- req_ready  out  1  sequencer can accept a request
- req_is_vector  in  1  1 = 6-lane vector load, 0 = scalar load
- req_addr  in  S  base word address
- req_stride  in  S  element stride in words; ignored for scalar loads
- req_tag  in  TAGW  destination register tag
- mem_is_vector  out  1  to ROM isVector
- mem_addr  out  S  to ROM address
- mem_rd  in  V  ROM read data (combinational)
- rsp_valid  out  1  response data valid
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  V  assembled load data; lane i = bits [i*S +: S]
- rsp_tag  out  TAGW  tag of the returning load
- rsp_err  out  1  bounds error flag; tied 0 without BOUNDS_CHECK_EN

Behaviour:
- States: IDLE, READ, GATHER, RESP.
- Reset: state IDLE; req_ready=1; rsp_valid=0; rsp_data=0; rsp_tag=0; rsp_err=0; mem_is_vector=0; mem_addr=0; lane counter=0.
- rst asserted mid-operation aborts the in-flight load. Nothing is returned for it.
- IDLE:
  - req_ready=1; mem outputs driven 0.
  - On req_valid at edge k: latch addr, stride, is_vector and tag; clear the data accumulator and err.
  - Go to READ if scalar or stride==1; otherwise go to GATHER with lane=0.
- READ (one cycle):
  - mem_is_vector = latched is_vector; mem_addr = latched addr.
  - At edge k+1: capture mem_rd into rsp_data, go to RESP.
  - Scalar loads return lanes 1..5 = 0, supplied by the ROM.
- GATHER:
  - mem_is_vector=0; mem_addr = addr + lane*stride, computed modulo 2^S (wrap-around permitted).
  - Each edge: write mem_rd[S-1:0] into lane `lane`, increment lane.
  - After lane 5 is written (edge k+6), go to RESP.
  - stride==0 is legal and broadcasts one word to all lanes.
- RESP:
  - rsp_valid=1; rsp_data, rsp_tag and rsp_err are held stable; req_ready=0.
  - On rsp_ready: go to IDLE at that edge and drop rsp_valid.
  - Next accept is possible at the following edge; there is no request/response overlap.
- Latency from accept edge to rsp_valid high: 1 cycle for scalar/contiguous, 6 cycles for gather.
- req_ready is combinational from state only; there is no combinational path from req_valid.
- Contiguous vector with addr+5 beyond 2^S-1: addresses wrap inside the ROM's index arithmetic; no special handling.

Optional Feature:
- Macro VLOAD_BOUNDS_CHECK_EN.
- Defined:
  - Each accessed lane address >= SIZE forces that lane to 0 and sets rsp_err.
  - Contiguous loads check addr+i for i=0..5; gather loads check each computed address; scalar loads check addr only.
  - rsp_err is sticky for that load.
- Undefined: no comparators are synthesized; rsp_err is constant 0; data passes through unmodified.

Decomposition:
- Package vload_pkg:
  - LANES=6.
  - State enum vload_state_t {IDLE, READ, GATHER, RESP}.
  - Lane-index type logic[2:0].
- One natural sub-module, vload_lane_pack: inserts an S-bit word into a selected lane of a V-bit register with a write enable, plus a clear. It is used by the gather path.

Test Plan:
- Scalar: ROM[100]=0xAAAA0001, req_is_vector=0, addr=100 -> rsp_valid 1 cycle after accept, rsp_data = {160'b0, 0xAAAA0001}, rsp_err=0.
- Contiguous: ROM[200..205]=1..6, stride=1 -> rsp_valid after 1 cycle; lanes 0..5 = 1..6; mem_is_vector=1 during READ.
- Gather: ROM[10+3i]=0x10+i, addr=10, stride=3 -> mem_addr sequence 10,13,16,19,22,25; rsp_valid after 6 cycles; lane i = 0x10+i.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> data/tag held stable, req_ready=0, a new req_valid is ignored; accepted 1 cycle after the rsp handshake.
- Reset mid-gather: assert rst at lane 3 -> next edge state IDLE, rsp_valid=0, req_ready=1, no response emitted; a following load completes normally.
- Bounds (macro on): addr=29998, stride=1 -> lanes 0,1 valid, lanes 2..5 = 0, rsp_err=1. Macro off -> rsp_err=0.

Source files
------------

// File: rtl/vload_pkg.sv
// Shared types and sizes for the vector load sequencer.
package vload_pkg;
    localparam int S     = 32;
    localparam int LANES = 6;
    localparam int V     = LANES * S;
    localparam int SIZE  = 30000;
    localparam int TAGW  = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        GATHER = 2'd2,
        RESP   = 2'd3
    } vload_state_t;

    typedef logic [2:0] lane_t;
endpackage

// File: rtl/vload_lane_pack.sv
// Inserts one S-bit word into a selected lane of a V-bit vector, with clear.
module vload_lane_pack
    import vload_pkg::*;
(
    input  logic [V-1:0] data_in,
    input  lane_t        lane,
    input  logic [S-1:0] word,
    input  logic         we,
    input  logic         clear,
    output logic [V-1:0] data_out
);
    always_comb begin
        data_out = data_in;
        if (clear) begin
            data_out = '0;
        end else if (we) begin
            for (int i = 0; i < LANES; i++) begin
                if (lane == lane_t'(i)) begin
                    data_out[i*S +: S] = word;
                end
            end
        end
    end
endmodule

// File: rtl/vload_sequencer.sv
// Load-stage sequencer driving the data ROM; gathers strided vectors lane by lane.
// Optional address bounds checking is enabled with `define VLOAD_BOUNDS_CHECK_EN.
module vload_sequencer
    import vload_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    // Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_is_vector,
    input  logic [S-1:0]    req_addr,
    input  logic [S-1:0]    req_stride,
    input  logic [TAGW-1:0] req_tag,
    output logic            mem_is_vector,
    output logic [S-1:0]    mem_addr,
    input  logic [V-1:0]    mem_rd,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [V-1:0]    rsp_data,
    output logic [TAGW-1:0] rsp_tag,
    output logic            rsp_err,
    output vload_state_t    state_dbg
);
    vload_state_t state_q, state_d;
    logic [S-1:0] cur_addr_q;
    logic [S-1:0] stride_q;
    logic         is_vec_q;
    lane_t        lane_q;
    logic [V-1:0] pack_out;
    logic [V-1:0] read_data;
    logic         read_err;
    logic [S-1:0] gather_word;
    logic         gather_err;

    assign state_dbg = state_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        req_ready     = 1'b0;
        rsp_valid     = 1'b0;
        mem_is_vector = 1'b0;
        mem_addr      = '0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = (!req_is_vector || req_stride == S'(1)) ? READ : GATHER;
                end
            end
            READ: begin
                mem_is_vector = is_vec_q;
                mem_addr      = cur_addr_q;
                state_d       = RESP;
            end
            GATHER: begin
                mem_addr = cur_addr_q;
                if (lane_q == lane_t'(LANES - 1)) state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef VLOAD_BOUNDS_CHECK_EN
    // Out-of-range lanes read as zero; scalar loads only own lane 0.
    always_comb begin
        logic [S-1:0] lane_addr;
        read_data = mem_rd;
        read_err  = 1'b0;
        lane_addr = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_addr = cur_addr_q + S'(i);
            if ((is_vec_q || i == 0) && lane_addr >= S'(SIZE)) begin
                read_data[i*S +: S] = '0;
                read_err            = 1'b1;
            end
        end
        gather_err  = (cur_addr_q >= S'(SIZE));
        gather_word = gather_err ? '0 : mem_rd[S-1:0];
    end
`else
    assign read_data   = mem_rd;
    assign read_err    = 1'b0;
    assign gather_err  = 1'b0;
    assign gather_word = mem_rd[S-1:0];
`endif

    vload_lane_pack u_pack (
        .data_in  (rsp_data),
        .lane     (lane_q),
        .word     (gather_word),
        .we       (state_q == GATHER),
        .clear    (state_q == IDLE),
        .data_out (pack_out)
    );

    // The gather address advances by stride each lane, wrapping modulo 2^S.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_addr_q <= '0;
            stride_q   <= '0;
            is_vec_q   <= 1'b0;
            lane_q     <= '0;
            rsp_data   <= '0;
            rsp_tag    <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        cur_addr_q <= req_addr;
                        stride_q   <= req_stride;
                        is_vec_q   <= req_is_vector;
                        rsp_tag    <= req_tag;
                        rsp_data   <= pack_out;
                        rsp_err    <= 1'b0;
                        lane_q     <= '0;
                    end
                end
                READ: begin
                    rsp_data <= read_data;
                    rsp_err  <= read_err;
                end
                GATHER: begin
                    rsp_data   <= pack_out;
                    rsp_err    <= rsp_err | gather_err;
                    lane_q     <= lane_q + 3'd1;
                    cur_addr_q <= cur_addr_q + stride_q;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_vload_sequencer.sv
// Directed bench for vload_sequencer with a behavioural ROM and response scoreboard.
`timescale 1ns/1ps
module tb_vload_sequencer;
    import vload_pkg::*;

    localparam int EW = V + TAGW + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid;
    logic            req_ready;
    logic            req_is_vector;
    logic [S-1:0]    req_addr;
    logic [S-1:0]    req_stride;
    logic [TAGW-1:0] req_tag;
    logic            mem_is_vector;
    logic [S-1:0]    mem_addr;
    logic [V-1:0]    mem_rd;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [V-1:0]    rsp_data;
    logic [TAGW-1:0] rsp_tag;
    logic            rsp_err;
    vload_state_t    state_dbg;

    int checks   = 0;
    int failures = 0;
    logic [EW-1:0] exp_q[$];

    always #5 clk = ~clk;

    vload_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_is_vector (req_is_vector),
        .req_addr      (req_addr),
        .req_stride    (req_stride),
        .req_tag       (req_tag),
        .mem_is_vector (mem_is_vector),
        .mem_addr      (mem_addr),
        .mem_rd        (mem_rd),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_tag       (rsp_tag),
        .rsp_err       (rsp_err),
        .state_dbg     (state_dbg)
    );

    // ROM contents: fixed test words plus an address-derived pattern elsewhere.
    function automatic logic [S-1:0] rom_word(input logic [S-1:0] a);
        if (a == 32'd100) return 32'hAAAA0001;
        if (a >= 32'd200 && a <= 32'd205) return a - 32'd199;
        if (a >= 32'd10 && a <= 32'd25 && ((a - 32'd10) % 32'd3) == 0)
            return 32'h10 + (a - 32'd10) / 32'd3;
        return {16'hBEEF, a[15:0]};
    endfunction

    function automatic logic [V-1:0] rom_read(input logic isv, input logic [S-1:0] a);
        logic [V-1:0] r;
        logic [S-1:0] la;
        r = '0;
        r[S-1:0] = rom_word(a);
        if (isv) begin
            for (int i = 1; i < LANES; i++) begin
                la = a + S'(i);
                r[i*S +: S] = rom_word(la);
            end
        end
        return r;
    endfunction

    assign mem_rd = rom_read(mem_is_vector, mem_addr);

    function automatic logic [EW-1:0] model(input logic isv, input logic [S-1:0] addr,
                                            input logic [S-1:0] stride, input logic [TAGW-1:0] tag);
        logic [V-1:0] d;
        logic         err;
        logic [S-1:0] a;
        logic [S-1:0] w;
        d   = '0;
        err = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (isv || i == 0) begin
                a = isv ? addr + S'(i) * stride : addr;
                w = rom_word(a);
`ifdef VLOAD_BOUNDS_CHECK_EN
                if (a >= S'(SIZE)) begin
                    w   = '0;
                    err = 1'b1;
                end
`endif
                d[i*S +: S] = w;
            end
        end
        return {err, tag, d};
    endfunction

    task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_load(input logic isv, input logic [S-1:0] addr, input logic [S-1:0] stride,
                            input logic [TAGW-1:0] tag, input int hold);
        logic         gather;
        int           lat;
        logic [S-1:0] ea;
        gather = isv && (stride != 32'd1);
        chk("req_ready_idle", EW'(req_ready), EW'(1'b1));
        req_valid     = 1'b1;
        req_is_vector = isv;
        req_addr      = addr;
        req_stride    = stride;
        req_tag       = tag;
        exp_q.push_back(model(isv, addr, stride, tag));
        @(negedge clk);
        req_valid  = 1'b0;
        req_addr   = $urandom;
        req_stride = $urandom;
        req_tag    = TAGW'($urandom);
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            ea = gather ? addr + S'(lat) * stride : addr;
            chk(gather ? "gather_addr" : "read_addr", EW'(mem_addr), EW'(ea));
            chk("mem_is_vector", EW'(mem_is_vector), EW'(gather ? 1'b0 : isv));
            chk("busy_req_ready", EW'(req_ready), EW'(1'b0));
            @(negedge clk);
            lat++;
        end
        chk("latency", EW'(lat), EW'(gather ? 6 : 1));
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1;
            chk("hold_valid", EW'(rsp_valid), EW'(1'b1));
            chk("hold_req_ready", EW'(req_ready), EW'(1'b0));
            chk("hold_data", {rsp_err, rsp_tag, rsp_data}, exp_q[0]);
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        chk("rsp_valid", EW'(rsp_valid), EW'(1'b1));
        if (exp_q.size() > 0) chk("rsp_payload", {rsp_err, rsp_tag, rsp_data}, exp_q.pop_front());
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", EW'(rsp_valid), EW'(1'b0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        req_valid     = 1'b0;
        req_is_vector = 1'b0;
        req_addr      = '0;
        req_stride    = '0;
        req_tag       = '0;
        rsp_ready     = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", EW'(req_ready), EW'(1'b1));
        chk("rst_rsp_valid", EW'(rsp_valid), EW'(1'b0));
        chk("rst_rsp", {rsp_err, rsp_tag, rsp_data}, '0);
        chk("rst_mem", EW'({mem_is_vector, mem_addr}), '0);
        chk("rst_state", EW'(state_dbg), EW'(IDLE));
        rst = 1'b0;
        @(negedge clk);

        run_load(1'b0, 32'd100, 32'd7, 5'd1, 0);
        run_load(1'b1, 32'd200, 32'd1, 5'd2, 0);
        run_load(1'b1, 32'd10, 32'd3, 5'd3, 0);
        run_load(1'b1, 32'd200, 32'd1, 5'd4, 5);
        run_load(1'b1, 32'd13, 32'd0, 5'd5, 2);

        // Abort a gather at lane 3 with reset.
        chk("abort_req_ready", EW'(req_ready), EW'(1'b1));
        req_valid = 1'b1; req_is_vector = 1'b1; req_addr = 32'd10; req_stride = 32'd3; req_tag = 5'd7;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_lane3_addr", EW'(mem_addr), EW'(32'd19));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_state", EW'(state_dbg), EW'(IDLE));
        chk("abort_rsp_valid", EW'(rsp_valid), EW'(1'b0));
        chk("abort_req_ready", EW'(req_ready), EW'(1'b1));
        chk("abort_rsp", {rsp_err, rsp_tag, rsp_data}, '0);
        run_load(1'b1, 32'd10, 32'd3, 5'd6, 1);

        run_load(1'b1, 32'd29998, 32'd1, 5'd8, 0);
        run_load(1'b1, 32'hFFFF_FFFC, 32'd2, 5'd9, 0);
        run_load(1'b1, 32'hFFFF_FFFE, 32'd1, 5'd10, 0);
        run_load(1'b0, 32'd29999, 32'd5, 5'd11, 0);
        run_load(1'b0, 32'd30000, 32'd1, 5'd12, 0);

        for (int n = 0; n < 8; n++) begin
            run_load(1'($urandom_range(0, 1)), S'($urandom_range(1, 40)),
                     S'($urandom_range(0, 4)), TAGW'($urandom_range(0, 31)),
                     int'($urandom_range(0, 2)));
        end

        chk("queue_empty", EW'(exp_q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
